b64_stream_enc: RTL and testbench

- Parametrised streaming Base64 encoder, successor to the fixed 7-bit ASCII-to-Base64 serial converter.
- Accepts one IN_W-bit symbol per handshake, packs symbols into an MSB-first bit accumulator, and emits 6-bit groups as Base64 alphabet characters.
- On message end it flushes the remaining bits zero-padded and optionally emits '=' until the character count is a multiple of 4.
- Sits between a symbol source (UART/ASCII front end) and a byte-oriented sink, with valid/ready on both sides.

---
 rtl/b64_pkg.sv | 29 ++
 rtl/b64_stream_enc_if.sv | 26 ++
 rtl/b64_alphabet.sv | 9 +
 rtl/b64_stream_enc.sv | 173 +++++++++++++++++
 tb/tb_b64_stream_enc.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/b64_pkg.sv
// rtl/b64_pkg.sv - shared types, constants and alphabet mapping for the Base64 stream encoder
package b64_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_PAD   = 2'd2
    } state_e;

    localparam logic [7:0] PAD_CHAR = 8'h3D;

    // Standard Base64 alphabet: A-Z, a-z, 0-9, '+', '/'
    function automatic logic [7:0] b64_char(input logic [5:0] idx);
        logic [7:0] i8;
        i8 = {2'b00, idx};
        if (idx < 6'd26) begin
            return 8'h41 + i8;
        end else if (idx < 6'd52) begin
            return 8'h61 + i8 - 8'd26;
        end else if (idx < 6'd62) begin
            return 8'h30 + i8 - 8'd52;
        end else if (idx == 6'd62) begin
            return 8'h2B;
        end else begin
            return 8'h2F;
        end
    endfunction

endpackage

// File: rtl/b64_stream_enc_if.sv
// rtl/b64_stream_enc_if.sv - symbol input and character output handshake bundle
interface b64_stream_enc_if #(
    parameter int IN_W = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic            out_pad;
    logic            out_last;

    // Environment side: supplies symbols and accepts characters
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_pad, out_last
    );

    // Encoder side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_pad, out_last
    );
endinterface

// File: rtl/b64_alphabet.sv
// rtl/b64_alphabet.sv - combinational 6-bit index to Base64 ASCII character map
module b64_alphabet
    import b64_pkg::*;
(
    input  logic [5:0] idx_i,
    output logic [7:0] char_o
);
    assign char_o = b64_char(idx_i);
endmodule

// File: rtl/b64_stream_enc.sv
// rtl/b64_stream_enc.sv - streaming Base64 encoder with bit accumulator, flush and '=' padding
module b64_stream_enc
    import b64_pkg::*;
#(
    parameter int IN_W   = 7,
    parameter bit PAD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    b64_stream_enc_if.slave  bus
);
    localparam int AW = IN_W + 5;
    localparam int CW = $clog2(IN_W + 6);
    localparam logic [CW-1:0] SIX  = CW'(6);
    localparam logic [CW-1:0] STEP = CW'(IN_W);

    state_e         state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     ccnt_q, ccnt_d;
    logic           last_q, last_d;

    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_pad_q, out_pad_d;
    logic           out_last_q, out_last_d;

    logic           in_fire;
    logic           out_fire;
    logic           finish;
    logic [5:0]     alpha_idx;
    logic [7:0]     alpha_char;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Next state of accumulator, counters and FSM; exit decisions use the updated counts
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ccnt_d  = ccnt_q;
        last_d  = last_q;
        finish  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (in_fire) begin
                    acc_d  = (acc_q << IN_W) | AW'(bus.in_data);
                    cnt_d  = cnt_q + STEP;
                    last_d = bus.in_last;
                end else if (out_fire) begin
                    cnt_d  = cnt_q - SIX;
                    ccnt_d = ccnt_q + 2'd1;
                end
                if (last_d && (cnt_d < SIX)) begin
                    if (cnt_d != '0) begin
                        state_d = S_FLUSH;
                    end else if (PAD_EN && (ccnt_d != 2'd0)) begin
                        state_d = S_PAD;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (out_fire) begin
                    ccnt_d = ccnt_q + 2'd1;
                    if (PAD_EN && (ccnt_d != 2'd0)) begin
                        state_d = S_PAD;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (out_fire) begin
                    ccnt_d = ccnt_q + 2'd1;
                    if (ccnt_d == 2'd0) begin
                        finish = 1'b1;
                    end
                end
            end
            default: finish = 1'b1;
        endcase
        if (finish) begin
            state_d = S_RUN;
            acc_d   = '0;
            cnt_d   = '0;
            ccnt_d  = 2'd0;
            last_d  = 1'b0;
        end
    end

    // Output flags and alphabet index derived from next state, so the outputs can be registered
    always_comb begin
        in_ready_d  = (state_d == S_RUN) && (cnt_d < SIX) && !last_d;
        out_valid_d = 1'b0;
        out_pad_d   = 1'b0;
        out_last_d  = 1'b0;
        alpha_idx   = 6'd0;
        case (state_d)
            S_RUN: begin
                if (cnt_d >= SIX) begin
                    out_valid_d = 1'b1;
                    alpha_idx   = 6'(acc_d >> (cnt_d - SIX));
                    // Final only if nothing remains to flush and no pad follows
                    out_last_d  = last_d && (cnt_d == SIX) && !(PAD_EN && (ccnt_d != 2'd3));
                end
            end
            S_FLUSH: begin
                out_valid_d = 1'b1;
                alpha_idx   = 6'(acc_d << (SIX - cnt_d));
                out_last_d  = !(PAD_EN && (ccnt_d != 2'd3));
            end
            S_PAD: begin
                out_valid_d = 1'b1;
                out_pad_d   = 1'b1;
                out_last_d  = (ccnt_d == 2'd3);
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    b64_alphabet u_alphabet (
        .idx_i  (alpha_idx),
        .char_o (alpha_char)
    );

    // Character select: pad, alphabet lookup, or idle zero
    always_comb begin
        out_data_d = 8'h00;
        if (out_valid_d) begin
            out_data_d = out_pad_d ? PAD_CHAR : alpha_char;
        end
    end

    // State and registered outputs; synchronous active-high reset discards any partial message
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            ccnt_q      <= 2'd0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_pad_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ccnt_q      <= ccnt_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pad_q   <= out_pad_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_pad   = out_pad_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_b64_stream_enc.sv
// tb/tb_b64_stream_enc.sv - bench for b64_stream_enc across IN_W=8/7 and PAD_EN=1/0
module tb_b64_stream_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'd0;
    logic       in_valid_tb = 1'b0;
    logic [7:0] in_data_tb = 8'h00;
    logic       in_last_tb = 1'b0;
    logic       out_ready_tb = 1'b0;

    logic       in_ready_m, out_valid_m, out_pad_m, out_last_m;
    logic [7:0] out_data_m;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] syms_q[$];
    string      got_s, exp_s;
    logic [63:0] got_padm, got_lastm, exp_padm, exp_lastm;
    int         nout;
    logic       timed_out;
    int         stall_bad, stall_seen;

    always #5 clk = ~clk;

    b64_stream_enc_if #(.IN_W(8)) if8 ();
    b64_stream_enc_if #(.IN_W(7)) if7 ();
    b64_stream_enc_if #(.IN_W(7)) if7n ();

    assign if8.in_valid   = in_valid_tb && (sel == 2'd0);
    assign if8.in_data    = in_data_tb;
    assign if8.in_last    = in_last_tb;
    assign if8.out_ready  = out_ready_tb;
    assign if7.in_valid   = in_valid_tb && (sel == 2'd1);
    assign if7.in_data    = in_data_tb[6:0];
    assign if7.in_last    = in_last_tb;
    assign if7.out_ready  = out_ready_tb;
    assign if7n.in_valid  = in_valid_tb && (sel == 2'd2);
    assign if7n.in_data   = in_data_tb[6:0];
    assign if7n.in_last   = in_last_tb;
    assign if7n.out_ready = out_ready_tb;

    b64_stream_enc #(.IN_W(8), .PAD_EN(1'b1)) u_enc8   (.clk(clk), .rst(rst), .bus(if8));
    b64_stream_enc #(.IN_W(7), .PAD_EN(1'b1)) u_enc7   (.clk(clk), .rst(rst), .bus(if7));
    b64_stream_enc #(.IN_W(7), .PAD_EN(1'b0)) u_enc7n  (.clk(clk), .rst(rst), .bus(if7n));

    // Observe the selected encoder
    always_comb begin
        case (sel)
            2'd1: begin
                in_ready_m = if7.in_ready; out_valid_m = if7.out_valid; out_data_m = if7.out_data;
                out_pad_m = if7.out_pad; out_last_m = if7.out_last;
            end
            2'd2: begin
                in_ready_m = if7n.in_ready; out_valid_m = if7n.out_valid; out_data_m = if7n.out_data;
                out_pad_m = if7n.out_pad; out_last_m = if7n.out_last;
            end
            default: begin
                in_ready_m = if8.in_ready; out_valid_m = if8.out_valid; out_data_m = if8.out_data;
                out_pad_m = if8.out_pad; out_last_m = if8.out_last;
            end
        endcase
    end

    function automatic int w_of(input logic [1:0] s);
        return (s == 2'd0) ? 8 : 7;
    endfunction

    function automatic bit pad_of(input logic [1:0] s);
        return (s != 2'd2);
    endfunction

    // Reference: concatenate symbol bits MSB-first, cut into 6-bit groups, zero-fill, pad with '='
    function automatic string model_enc(input int w, input bit pad_en);
        bit    bits[$];
        string s;
        string alpha;
        int    nc;
        int    v;
        alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
        s = "";
        foreach (syms_q[k]) begin
            for (int b = w - 1; b >= 0; b--) bits.push_back(syms_q[k][b]);
        end
        nc = (bits.size() + 5) / 6;
        for (int c = 0; c < nc; c++) begin
            v = 0;
            for (int k = 0; k < 6; k++) begin
                v = v * 2 + (((c * 6 + k) < bits.size()) ? int'(bits[c * 6 + k]) : 0);
            end
            s = $sformatf("%s%c", s, alpha[v]);
        end
        if (pad_en) begin
            while ((s.len() % 4) != 0) s = {s, "="};
        end
        return s;
    endfunction

    function automatic void set_exp(input string s);
        exp_s     = s;
        exp_padm  = '0;
        for (int i = 0; i < s.len(); i++) exp_padm[i] = (s[i] == 8'h3D);
        exp_lastm = 64'd1 << (s.len() - 1);
    endfunction

    function automatic void load_rand(input int w, input int n);
        syms_q.delete();
        for (int i = 0; i < n; i++) syms_q.push_back(8'($urandom_range(0, (1 << w) - 1)));
    endfunction

    // Drive syms_q into the selected encoder and capture its characters.
    // mode 0: always ready; 1: random in_valid gaps and out_ready; 2: 10-cycle out_ready stall
    task automatic run_msg(input int stop_after, input int mode);
        int         n;
        int         idx;
        bit         stalled;
        bit         done;
        logic [9:0] held;
        n = syms_q.size(); idx = 0; stalled = 1'b0; done = 1'b0; held = '0;
        got_s = ""; got_padm = '0; got_lastm = '0; nout = 0;
        timed_out = 1'b1; stall_bad = 0; stall_seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (stop_after >= 0 && idx >= stop_after) begin
                timed_out = 1'b0;
                break;
            end
            in_valid_tb = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_data_tb  = (idx < n) ? syms_q[idx] : 8'h00;
            in_last_tb  = (idx == n - 1);
            if (mode == 1)      out_ready_tb = ($urandom_range(0, 1) == 1);
            else if (mode == 2) out_ready_tb = !(cyc >= 3 && cyc < 13);
            else                out_ready_tb = 1'b1;
            if (stalled) begin
                stall_seen++;
                if (!out_valid_m || {out_data_m, out_pad_m, out_last_m} !== held) stall_bad++;
            end
            if (in_valid_tb && in_ready_m) idx++;
            if (out_valid_m && out_ready_tb) begin
                got_s = $sformatf("%s%c", got_s, out_data_m);
                if (nout < 64) begin
                    got_padm[nout]  = out_pad_m;
                    got_lastm[nout] = out_last_m;
                end
                nout++;
                done = out_last_m;
            end
            stalled = out_valid_m && !out_ready_tb;
            held    = {out_data_m, out_pad_m, out_last_m};
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        in_valid_tb  = 1'b0;
        in_last_tb   = 1'b0;
        out_ready_tb = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({in_ready_m, out_valid_m, out_data_m, out_pad_m, out_last_m} !== 12'h000) begin
                errors++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b data=%h pad=%b last=%b required all zero",
                         s, in_ready_m, out_valid_m, out_data_m, out_pad_m, out_last_m);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({in_ready_m, out_valid_m} !== 2'b10) begin
                errors++;
                $display("FAIL post_reset[%0d]: got in_ready=%b out_valid=%b required 1 0", s, in_ready_m, out_valid_m);
            end
        end
        sel = 2'd0;
    endtask

    task automatic test_vectors();
        string name;
        for (int v = 0; v < 5; v++) begin
            syms_q.delete();
            case (v)
                0: begin sel = 2'd0; syms_q = '{8'h4D, 8'h61, 8'h6E}; set_exp("TWFu"); name = "man8"; end
                1: begin sel = 2'd0; syms_q = '{8'h4D, 8'h61};        set_exp("TWE=");  name = "ma8"; end
                2: begin sel = 2'd0; syms_q = '{8'h4D};               set_exp("TQ==");  name = "m8"; end
                3: begin sel = 2'd1; syms_q = '{8'h41, 8'h42};        set_exp("gwg=");  name = "ab7"; end
                default: begin sel = 2'd2; syms_q = '{8'h41, 8'h42};  set_exp("gwg");   name = "ab7_nopad"; end
            endcase
            run_msg(-1, 0);
            checks++;
            if (timed_out !== 1'b0) begin errors++; $display("FAIL %s_timeout: got timed_out=%b required 0", name, timed_out); end
            checks++;
            if (got_s != exp_s) begin errors++; $display("FAIL %s_chars: got \"%s\" required \"%s\"", name, got_s, exp_s); end
            checks++;
            if (got_padm !== exp_padm) begin errors++; $display("FAIL %s_pad: got %h required %h", name, got_padm, exp_padm); end
            checks++;
            if (got_lastm !== exp_lastm) begin errors++; $display("FAIL %s_last: got %h required %h", name, got_lastm, exp_lastm); end
        end
    endtask

    task automatic test_backpressure();
        for (int m = 0; m < 3; m++) begin
            sel = 2'(m);
            load_rand(w_of(sel), 9);
            set_exp(model_enc(w_of(sel), pad_of(sel)));
            run_msg(-1, (m == 1) ? 1 : 2);
            checks++;
            if (timed_out !== 1'b0) begin errors++; $display("FAIL bp%0d_timeout: got timed_out=%b required 0", m, timed_out); end
            checks++;
            if (got_s != exp_s) begin errors++; $display("FAIL bp%0d_chars: got \"%s\" required \"%s\"", m, got_s, exp_s); end
            checks++;
            if (got_padm !== exp_padm) begin errors++; $display("FAIL bp%0d_pad: got %h required %h", m, got_padm, exp_padm); end
            checks++;
            if (got_lastm !== exp_lastm) begin errors++; $display("FAIL bp%0d_last: got %h required %h", m, got_lastm, exp_lastm); end
            checks++;
            if (stall_bad !== 0) begin errors++; $display("FAIL bp%0d_stable: got %0d unstable stall cycles required 0", m, stall_bad); end
            checks++;
            if (stall_seen < 1) begin errors++; $display("FAIL bp%0d_stalled: got %0d stall cycles required >=1", m, stall_seen); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 18; r++) begin
            sel = 2'(r % 3);
            load_rand(w_of(sel), $urandom_range(1, 14));
            set_exp(model_enc(w_of(sel), pad_of(sel)));
            run_msg(-1, (r % 2 == 0) ? 1 : 0);
            checks++;
            if (timed_out !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got timed_out=%b required 0", r, timed_out); end
            checks++;
            if (got_s != exp_s) begin errors++; $display("FAIL rnd%0d_chars: got \"%s\" required \"%s\"", r, got_s, exp_s); end
            checks++;
            if (got_padm !== exp_padm) begin errors++; $display("FAIL rnd%0d_pad: got %h required %h", r, got_padm, exp_padm); end
            checks++;
            if (got_lastm !== exp_lastm) begin errors++; $display("FAIL rnd%0d_last: got %h required %h", r, got_lastm, exp_lastm); end
        end
    endtask

    task automatic test_mid_reset();
        sel = 2'd0;
        syms_q = '{8'h4D, 8'h61, 8'h6E};
        run_msg(2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready_m, out_valid_m, out_pad_m, out_last_m} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_state: got rdy=%b vld=%b pad=%b last=%b required 0 0 0 0",
                     in_ready_m, out_valid_m, out_pad_m, out_last_m);
        end
        rst = 1'b0;
        syms_q = '{8'h4D, 8'h61, 8'h6E};
        set_exp("TWFu");
        run_msg(-1, 0);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got timed_out=%b required 0", timed_out); end
        checks++;
        if (got_s != exp_s) begin errors++; $display("FAIL midrst_chars: got \"%s\" required \"%s\"", got_s, exp_s); end
        checks++;
        if (got_lastm !== exp_lastm) begin errors++; $display("FAIL midrst_last: got %h required %h", got_lastm, exp_lastm); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
